// File: rtl/prco_uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO in front of the shifter.
// Exposes FIFO-full, busy and sticky-overflow status to the core.
module prco_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_new_data,
    input  logic [7:0] i_data,
    output logic       q_tx,
    output logic       q_full,
    output logic       q_busy,
    output logic       q_overflow
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [PtrW:0]   DepthC   = (PtrW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] baud_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW:0]   count_q;

    logic fifo_empty;
    logic bit_end;
    logic push;
    logic pop;

    assign fifo_empty = (count_q == '0);
    assign bit_end    = (baud_q == BaudLast);
    // Acceptance is judged on the pre-edge count, so a same-cycle pop cannot rescue a full FIFO.
    assign push       = i_new_data && (count_q != DepthC);
    assign pop        = !fifo_empty &&
                        ((state_q == StIdle) || ((state_q == StStop) && bit_end));

    assign q_full = (count_q == DepthC);
    assign q_busy = (state_q != StIdle) || !fifo_empty;

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            q_overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (i_new_data && !push) begin
                q_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            q_tx      <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    q_tx <= 1'b1;
                    if (pop) begin
                        shift_q <= mem_q[rd_ptr_q];
                        q_tx    <= 1'b0;
                        baud_q  <= '0;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        baud_q    <= '0;
                        q_tx      <= shift_q[0];
                        bit_idx_q <= '0;
                        state_q   <= StData;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            q_tx    <= 1'b1;
                            state_q <= StStop;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            q_tx      <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        // Back-to-back frames: the next start bit begins on this same edge.
                        if (pop) begin
                            shift_q <= mem_q[rd_ptr_q];
                            q_tx    <= 1'b0;
                            state_q <= StStart;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    q_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prco_uart_tx.sv
// Drives two transmitters (4 and 2 clocks per bit) with identical stimulus and
// compares every cycle against a frame-timeline reference model.
module tb_prco_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       new_data = 1'b0;
    logic [7:0] data = 8'h00;
    logic       tx4, full4, busy4, ovf4;
    logic       tx2, full2, busy2, ovf2;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state, index 0 -> 4 clocks/bit, 1 -> 2 clocks/bit.
    int         clks   [2] = '{4, 2};
    logic [7:0] mf     [2][4];
    int         cnt    [2];
    int         rdp    [2];
    int         wrp    [2];
    int         lastp  [2];
    bit         hp     [2];
    logic [7:0] cur    [2];
    bit         ov     [2];

    always #5 clk = ~clk;

    prco_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut4 (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_new_data (new_data),
        .i_data     (data),
        .q_tx       (tx4),
        .q_full     (full4),
        .q_busy     (busy4),
        .q_overflow (ovf4)
    );

    prco_uart_tx #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4)) dut2 (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_new_data (new_data),
        .i_data     (data),
        .q_tx       (tx2),
        .q_full     (full2),
        .q_busy     (busy2),
        .q_overflow (ovf2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            cnt[d] = 0; rdp[d] = 0; wrp[d] = 0; lastp[d] = 0;
            hp[d] = 0; cur[d] = 8'h00; ov[d] = 0;
        end
    endtask

    task automatic model_edge(input int d, input logic nd, input logic [7:0] din);
        bit pop;
        bit acc;
        pop = (cnt[d] > 0) && (!hp[d] || (cyc >= lastp[d] + 10 * clks[d]));
        acc = nd && (cnt[d] < 4);
        if (pop) begin
            cur[d]   = mf[d][rdp[d]];
            rdp[d]   = (rdp[d] + 1) % 4;
            lastp[d] = cyc;
            hp[d]    = 1;
        end
        if (acc) begin
            mf[d][wrp[d]] = din;
            wrp[d] = (wrp[d] + 1) % 4;
        end
        if (nd && !acc) ov[d] = 1;
        cnt[d] = cnt[d] + int'(acc) - int'(pop);
    endtask

    function automatic bit in_frame(input int d);
        return hp[d] && (cyc < lastp[d] + 10 * clks[d]);
    endfunction

    function automatic logic exp_tx(input int d);
        int k;
        if (!in_frame(d)) return 1'b1;
        k = (cyc - lastp[d]) / clks[d];
        if (k == 0) return 1'b0;
        if (k <= 8) return cur[d][k-1];
        return 1'b1;
    endfunction

    task automatic compare_all();
        check_eq("tx_c4",   tx4,   exp_tx(0));
        check_eq("busy_c4", busy4, (cnt[0] > 0) || in_frame(0));
        check_eq("full_c4", full4, cnt[0] == 4);
        check_eq("ovf_c4",  ovf4,  ov[0]);
        check_eq("tx_c2",   tx2,   exp_tx(1));
        check_eq("busy_c2", busy2, (cnt[1] > 0) || in_frame(1));
        check_eq("full_c2", full2, cnt[1] == 4);
        check_eq("ovf_c2",  ovf2,  ov[1]);
    endtask

    task automatic step(input logic nd, input logic [7:0] din);
        @(negedge clk);
        new_data = nd;
        data     = din;
        @(posedge clk);
        cyc++;
        model_edge(0, nd, din);
        model_edge(1, nd, din);
        #1;
        new_data = 1'b0;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    // Reset is asserted mid-phase so its effect on q_tx is seen without a clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_tx_c4",   tx4,   1'b1);
        check_eq("rst_busy_c4", busy4, 1'b0);
        check_eq("rst_full_c4", full4, 1'b0);
        check_eq("rst_ovf_c4",  ovf4,  1'b0);
        check_eq("rst_tx_c2",   tx2,   1'b1);
        check_eq("rst_busy_c2", busy2, 1'b0);
        check_eq("rst_ovf_c2",  ovf2,  1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int guard;
        model_reset();
        do_reset();

        // Single frame 0xA5.
        step(1'b1, 8'hA5);
        idle(45);

        // Back-to-back 0x00 then 0xFF.
        step(1'b1, 8'h00);
        step(1'b1, 8'hFF);
        idle(90);

        // Six consecutive writes: fill and overflow.
        for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom));
        idle(220);

        // Alternating pattern, visible at 2 clocks per bit too.
        step(1'b1, 8'h55);
        idle(45);

        // Reset in the middle of a data bit, then confirm the line stays idle.
        step(1'b1, 8'h3C);
        idle(13);
        do_reset();
        idle(50);

        // Full FIFO plus a write on the exact stop-to-start pop edge.
        step(1'b1, 8'h11);
        for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom));
        guard = 0;
        while ((cyc + 1 != lastp[0] + 40) && (guard < 100)) begin
            step(1'b0, 8'h00);
            guard++;
        end
        check_eq("pop_edge_found", guard < 100, 1'b1);
        step(1'b1, 8'hEE);
        check_eq("ovf_at_pop", ovf4, 1'b1);
        check_eq("full_dropped", full4, 1'b0);
        idle(250);

        // Randomized traffic with bursts.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 1 : 4), 8'($urandom));
        end
        idle(300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prco_uart_tx.md
Name: prco_uart_tx

Overview:
- 8N1 UART transmitter that serialises the bytes the processor I/O stage presents as its UART1 transmit data.
- The upstream I/O stage drives a one-cycle write strobe alongside the byte; this block queues bytes in a small FIFO and shifts them out on a single serial line.
- Its output is the chip-level UART1 TX pin. It exposes FIFO-full, busy and sticky-overflow status for the core to poll.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal range >= 2.
- FIFO_DEPTH, 4, byte entries in the transmit FIFO; power of two, >= 2.

Ports:
- i_clk  input  1  system clock, all logic on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_new_data  input  1  write strobe; one byte is offered per cycle high.
- i_data  input  8  byte to transmit, sampled when i_new_data=1.
- q_tx  output  1  serial line; idles high.
- q_full  output  1  FIFO holds FIFO_DEPTH entries.
- q_busy  output  1  frame in progress or FIFO non-empty.
- q_overflow  output  1  sticky; set when a write is dropped.

Behaviour:
- Reset (i_rst_n=0, asynchronous): q_tx=1, q_full=0, q_busy=0, q_overflow=0. FIFO count and pointers go to 0, the FSM goes to IDLE, and all counters clear. A frame in flight is abandoned and q_tx returns high without waiting for a clock. q_overflow clears only on reset.
- FIFO write: accepted at edge E when i_new_data=1 and count<FIFO_DEPTH, judged on the pre-edge count.
  - When count==FIFO_DEPTH the write is dropped and q_overflow is set at E. This holds even if a pop happens in the same cycle.
  - A simultaneous write and pop leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - q_full = (count==FIFO_DEPTH), registered or derived directly from the count register.
- FSM states:
  - IDLE: q_tx=1. If count>0 at edge E, pop the head into the shift register, set q_tx=0 at E, clear the baud counter, go to START.
  - START: hold q_tx=0 for CLKS_PER_BIT cycles, then drive shift[0], bit index=0, go to DATA.
  - DATA: each bit is held CLKS_PER_BIT cycles. Bits go out LSB first. After bit 7's period, drive q_tx=1 and go to STOP.
  - STOP: hold q_tx=1 for CLKS_PER_BIT cycles. At the end of the period:
    - if count>0, pop, drive q_tx=0 on that same edge and go to START (back-to-back, no idle gap);
    - otherwise go to IDLE.
- Frame length: exactly 10*CLKS_PER_BIT cycles from the falling start edge to the end of the stop bit.
- Latency: with the FIFO empty and FSM IDLE, a byte written at edge E reaches the FIFO at E. q_tx falls at edge E+1.
- Baud counter: counts 0..CLKS_PER_BIT-1, width clog2(CLKS_PER_BIT). Bit index is 3 bits.
- q_busy = (state!=IDLE) or (count>0).
- Writes during an active frame never disturb the bit currently being shifted.

Test Plan:
1. CLKS_PER_BIT=4: reset, then write 0xA5 at edge E -> q_tx falls at E+1; sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles). q_busy stays high throughout and drops in the cycle after the stop bit ends.
2. Write 0x00 then 0xFF on consecutive cycles -> two contiguous 40-cycle frames with no idle cycles between the first stop bit and the second start bit. The second frame's data bits are all 1.
3. FIFO_DEPTH=4, write 6 bytes on consecutive edges E0..E5 -> bytes 1-5 accepted (byte 1 popped at E1). q_full=1 after E4. Byte 6 dropped and q_overflow=1 after E5. Exactly 5 frames are transmitted.
4. Assert i_rst_n=0 mid-way through a data bit -> q_tx=1 immediately, before the next clock. q_busy=0, q_full=0, q_overflow=0. After release the line stays idle high with no residual frame.
5. While the FIFO is full, assert i_new_data in the exact cycle of a pop at the stop-to-start transition -> the write is rejected, q_overflow=1, and count drops by one.
6. CLKS_PER_BIT=2, send 0x55 -> 20-cycle frame alternating 0,1,0,1,... with each bit exactly 2 cycles wide.
